seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumes the scan tick produced by `clock_divider` (`clk_scan`, retimed by the integrator into a single-cycle `clk`-domain pulse).
- Time-multiplexes NUM_DIGITS hex digits onto a common-anode seven-segment display.
- Inserts a programmable anode-off blanking gap before each digit to prevent ghosting.
- Snapshots the display data once per frame so digits never tear mid-scan. Sits between the game score/timer logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
- BLANK_CYCLES, 2, `clk` cycles with all anodes off after each tick; legal range 0..255.
- LZS, 0, 1 = leading-zero suppression enabled.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- scan_tick  input  1  single-cycle pulse; each pulse advances to the next digit.
- digits  input  4*NUM_DIGITS  hex digit values; digit i is digits[4i+3:4i]; digit 0 is the rightmost digit.
- blank  input  NUM_DIGITS  1 forces digit i fully dark, including its dp.
- dp_en  input  NUM_DIGITS  1 lights the decimal point of digit i.
- an  output  NUM_DIGITS  active-low anode enables; an[i] drives digit i.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- digit_idx  output  max(1,$clog2(NUM_DIGITS))  index of the currently selected digit.
- frame_start  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset values (synchronous, rst=1 at an edge):
  - an = all 1s, seg = 7'h7F, dp = 1, frame_start = 0.
  - digit_idx = NUM_DIGITS-1, so the first tick selects digit 0.
  - state = IDLE; blank counter = 0; shadow registers = 0.
- Reset wins over scan_tick in the same cycle. Reset mid-scan darkens the display on the next edge.
- All outputs are registered.
- State machine: IDLE, BLANK, DRIVE.
  - IDLE: outputs dark; waits for scan_tick.
  - Any state, on an edge with scan_tick=1:
    - digit_idx <= digit_idx+1, wrapping NUM_DIGITS-1 -> 0.
    - an <= all 1s, seg <= 7'h7F, dp <= 1.
    - cnt <= BLANK_CYCLES; state <= BLANK.
  - A tick arriving during BLANK restarts the gap on the next digit. The skipped digit is not shown; this is not an error.
  - BLANK, no tick: if cnt == 0, drive the selected digit and go to DRIVE; else cnt <= cnt-1.
  - DRIVE: hold outputs until the next tick.
- Latency:
  - Tick sampled at edge T gives the digit visible after edge T+BLANK_CYCLES+1.
  - BLANK_CYCLES = 0 gives drive at T+1.
- Frame snapshot:
  - On the tick edge where digit_idx wraps to 0, latch digits, blank and dp_en into shadow registers.
  - frame_start = 1 for exactly that one cycle.
  - All decode uses shadow values only. Input changes mid-frame take effect at the next frame.
- Drive values for selected digit i:
  - an = ~(1<<i).
  - If shadow blank[i] = 1: seg = 7'h7F and dp = 1, but the anode is still enabled (keeps scan timing uniform).
  - Otherwise seg = hex decode of the shadow digit and dp = ~dp_en[i].
- Hex decode, active-low, {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- LZS = 1: digit i (i != 0) has seg = 7'h7F when shadow digits i..NUM_DIGITS-1 are all zero. dp is unaffected. Digit 0 always shows.
- Exactly one anode is low in DRIVE. No anode is low in IDLE or BLANK.

Test Plan:
- Reset with scan_tick=1 asserted -> an=4'hF, seg=7F, dp=1, frame_start=0, digit_idx=3 after the edge.
- NUM_DIGITS=4, BLANK_CYCLES=2, digits=16'h1234, ticks every 10 cycles:
  - first tick -> frame_start pulse, digit_idx=0.
  - an=4'hF for 3 edges, then an=4'hE, seg=19.
  - subsequent ticks -> 4'hD/30, 4'hB/24, 4'h7/79; the 5th tick pulses frame_start again.
- Change digits to 16'hFFFF right after frame_start -> digits 1..3 still show 3,2,1. The next frame shows 0E on every digit.
- Two ticks 1 cycle apart during BLANK -> digit_idx advances twice, no anode goes low between them, and the second digit is driven BLANK_CYCLES+1 edges after the second tick.
- LZS=1, digits=16'h0007, dp_en=4'b0100, blank=0:
  - digit 0 -> seg=78.
  - digit 2 -> seg=7F, dp=0.
  - digits 1, 3 -> seg=7F, dp=1.
- BLANK_CYCLES=0, blank=4'b0001 -> on digit 0, an=4'hE, seg=7F, dp=1 one edge after the tick. Assert rst in DRIVE -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode seven-segment scan driver
// Blanking gap before each digit, per-frame shadow snapshot, optional leading-zero suppression.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 2,
  parameter bit LZS          = 1'b0,
  localparam int IW          = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_start
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t                  state, state_nxt;
  logic [7:0]              cnt, cnt_nxt;
  logic [IW-1:0]           idx_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic                    fs_nxt;
  logic [4*NUM_DIGITS-1:0] sh_digits, sh_digits_nxt;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_nxt;
  logic [NUM_DIGITS-1:0]   sh_dp_en, sh_dp_en_nxt;

  logic [NUM_DIGITS-1:0]   sel_an;
  logic [6:0]              sel_seg;
  logic                    sel_dp;
  logic [3:0]              sel_digit;
  logic                    lead_zero;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Drive values for the selected digit, always taken from the frame snapshot
  always_comb begin
    sel_digit = sh_digits[4*digit_idx +: 4];
    lead_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(digit_idx) && sh_digits[4*j +: 4] != 4'h0) lead_zero = 1'b0;
    end
    sel_an = ~(NUM_DIGITS'(1) << digit_idx);
    if (sh_blank[digit_idx]) begin
      sel_seg = 7'h7F;
      sel_dp  = 1'b1;
    end else begin
      sel_seg = (LZS && digit_idx != '0 && lead_zero) ? 7'h7F : hex7(sel_digit);
      sel_dp  = ~sh_dp_en[digit_idx];
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = digit_idx;
    an_nxt        = an;
    seg_nxt       = seg;
    dp_nxt        = dp;
    fs_nxt        = 1'b0;
    sh_digits_nxt = sh_digits;
    sh_blank_nxt  = sh_blank;
    sh_dp_en_nxt  = sh_dp_en;
    if (scan_tick) begin
      idx_nxt   = (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
      an_nxt    = '1;
      seg_nxt   = 7'h7F;
      dp_nxt    = 1'b1;
      cnt_nxt   = 8'(BLANK_CYCLES);
      state_nxt = BLANK;
      if (digit_idx == LAST_IDX) begin
        fs_nxt        = 1'b1;
        sh_digits_nxt = digits;
        sh_blank_nxt  = blank;
        sh_dp_en_nxt  = dp_en;
      end
    end else begin
      case (state)
        IDLE: ;
        BLANK: begin
          if (cnt == 8'd0) begin
            an_nxt    = sel_an;
            seg_nxt   = sel_seg;
            dp_nxt    = sel_dp;
            state_nxt = DRIVE;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        DRIVE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      digit_idx   <= LAST_IDX;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      sh_digits   <= '0;
      sh_blank    <= '0;
      sh_dp_en    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      digit_idx   <= idx_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      frame_start <= fs_nxt;
      sh_digits   <= sh_digits_nxt;
      sh_blank    <= sh_blank_nxt;
      sh_dp_en    <= sh_dp_en_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - bench for seg7_scan_driver
// Two instances (gap 2 / no LZS, gap 0 / LZS) share stimulus and one timing-level reference model.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_tick = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  dp_en = 4'h0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [1:0] idx_a, idx_b;
  logic       fs_a, fs_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(2), .LZS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .digits(digits), .blank(blank),
    .dp_en(dp_en), .an(an_a), .seg(seg_a), .dp(dp_a), .digit_idx(idx_a), .frame_start(fs_a)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(0), .LZS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .digits(digits), .blank(blank),
    .dp_en(dp_en), .an(an_b), .seg(seg_b), .dp(dp_b), .digit_idx(idx_b), .frame_start(fs_b)
  );

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference: which digit was last selected, when its tick came, and the frame snapshot
  int          cyc = 0;
  int          m_idx = 3;
  int          m_tick_cyc = 0;
  bit          m_started = 0;
  bit          m_fs = 0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_blank = 4'h0;
  logic [3:0]  m_dpen = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    m_fs = 0;
    if (rst) begin
      m_idx = 3; m_started = 0; m_dig = 0; m_blank = 0; m_dpen = 0;
    end else if (scan_tick) begin
      m_idx = (m_idx + 1) % 4;
      m_tick_cyc = cyc;
      m_started = 1;
      if (m_idx == 0) begin
        m_fs = 1; m_dig = digits; m_blank = blank; m_dpen = dp_en;
      end
    end
  endtask

  task automatic expect_out(input int gap, input bit lzs,
                            output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
    bit lz;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_started && (cyc - m_tick_cyc) >= gap + 1) begin
      e_an[m_idx] = 1'b0;
      lz = 1;
      for (int j = m_idx; j < 4; j++) if (m_dig[4*j +: 4] != 4'h0) lz = 0;
      if (!m_blank[m_idx]) begin
        e_dp = ~m_dpen[m_idx];
        if (!(lzs && m_idx != 0 && lz)) e_seg = hex_tab[m_dig[4*m_idx +: 4]];
      end
    end
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    expect_out(2, 1'b0, e_an, e_seg, e_dp);
    check("a_an", an_a, e_an);
    check("a_seg", seg_a, e_seg);
    check("a_dp", dp_a, e_dp);
    check("a_idx", idx_a, m_idx);
    check("a_fs", fs_a, m_fs);
    expect_out(0, 1'b1, e_an, e_seg, e_dp);
    check("b_an", an_b, e_an);
    check("b_seg", seg_b, e_seg);
    check("b_dp", dp_b, e_dp);
    check("b_idx", idx_b, m_idx);
    check("b_fs", fs_b, m_fs);
  endtask

  task automatic tick_then(input int idle);
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    for (int i = 0; i < idle; i++) step();
  endtask

  initial begin
    rst = 1'b1; scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    step();
    rst = 1'b0;
    step();

    digits = 16'h1234;
    tick_then(9);
    digits = 16'hFFFF;
    for (int k = 0; k < 4; k++) tick_then(9);

    tick_then(1);
    tick_then(8);

    digits = 16'h0007; dp_en = 4'b0100; blank = 4'h0;
    for (int k = 0; k < 8; k++) tick_then(5);

    digits = 16'hA5C3; dp_en = 4'h0; blank = 4'b0001;
    for (int k = 0; k < 8; k++) tick_then(4);
    tick_then(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    for (int n = 0; n < 3000; n++) begin
      scan_tick = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) begin
        digits = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        blank  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        dp_en  = 4'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
